down_counter: RTL



---
 rtl/down_counter_if.sv | 25 ++
 rtl/down_counter.sv | 89 ++++++++
 2 files changed

// File: rtl/down_counter_if.sv
// Load handshake and status bundle for the down_counter timer.
// The master side issues loads and controls counting; the slave side is the counter.
interface down_counter_if #(
  parameter int N = 7
);
  logic         load_valid;
  logic         load_ready;
  logic [N:0]   load_value;
  logic         reload;
  logic         enable;
  logic         stop;
  logic [N:0]   count;
  logic         busy;
  logic         done;

  modport master (
    output load_valid, load_value, reload, enable, stop,
    input  load_ready, count, busy, done
  );

  modport slave (
    input  load_valid, load_value, reload, enable, stop,
    output load_ready, count, busy, done
  );
endinterface

// File: rtl/down_counter.sv
// Loadable, programmable-period down-counter with one-shot and auto-reload modes.
// A load of value V with enable held high produces a one-cycle done pulse V
// cycles later; in auto-reload mode the pulse repeats every V enabled cycles.
module down_counter #(
  parameter int N = 7
) (
  input  logic          clock,
  input  logic          clear_n,
  down_counter_if.slave bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t     r_state;
  logic [N:0] r_count;
  logic [N:0] r_period;
  logic       r_reload;
  logic       r_done;

  logic       w_load_fire;
  logic       w_load_zero;
  logic       w_terminal;

  // A load is taken only while idle; a zero load never enters RUN.
  assign w_load_fire = bus.load_valid && (r_state == S_IDLE);
  assign w_load_zero = (bus.load_value == '0);
  // Count of one is the last enabled cycle before terminal count.
  assign w_terminal  = (r_count == {{N{1'b0}}, 1'b1});

  // Control FSM with count, period, mode and done pulse all registered together.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_period <= '0;
      r_reload <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // done is a pulse unless re-asserted below on this edge.
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_load_fire) begin
            r_count  <= bus.load_value;
            r_period <= bus.load_value;
            r_reload <= bus.reload;
            if (w_load_zero) begin
              // Zero-length period: report completion without ever running.
              r_done <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (bus.stop) begin
            // Abort wins over a coincident terminal count; count is frozen.
            r_state <= S_IDLE;
          end else if (bus.enable) begin
            if (w_terminal) begin
              r_done <= 1'b1;
              if (r_reload) begin
                r_count <= r_period;
              end else begin
                r_count <= '0;
                r_state <= S_IDLE;
              end
            end else if (r_count != '0) begin
              // Guarded so the count can never wrap below zero.
              r_count <= r_count - 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.load_ready = (r_state == S_IDLE);
  assign bus.busy       = (r_state == S_RUN);
  assign bus.count      = r_count;
  assign bus.done       = r_done;

endmodule
